// File: rtl/edge_detect_multi.sv
// Multi-channel input conditioner: synchroniser, glitch filter and selectable
// edge detection per channel, with a sticky flag and saturating event counter.

module edge_detect_multi #(
   parameter int CHANNELS    = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3,
   parameter int CNT_W       = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       sig,
   input  logic [2*CHANNELS-1:0]     mode,
   input  logic [CHANNELS-1:0]       clr,
   output logic [CHANNELS-1:0]       level,
   output logic [CHANNELS-1:0]       pe,
   output logic [CHANNELS-1:0]       flag,
   output logic [CNT_W*CHANNELS-1:0] count
);
   logic [CHANNELS-1:0][1:0]       mode_a;
   logic [CHANNELS-1:0][CNT_W-1:0] count_a;

   assign mode_a = mode;
   assign count  = count_a;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      edge_detect_lane #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILTER_LEN  (FILTER_LEN),
         .CNT_W       (CNT_W)
      ) u_lane (
         .clk   (clk),
         .rst   (rst),
         .sig   (sig[i]),
         .mode  (mode_a[i]),
         .clr   (clr[i]),
         .level (level[i]),
         .pe    (pe[i]),
         .flag  (flag[i]),
         .count (count_a[i])
      );
   end
endmodule

module edge_detect_lane #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig,
   input  logic [1:0]       mode,
   input  logic             clr,
   output logic             level,
   output logic             pe,
   output logic             flag,
   output logic [CNT_W-1:0] count
);
   localparam int               FC_W    = $clog2(FILTER_LEN + 1);
   localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FILTER_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [FC_W-1:0]        fc, fc_nxt;
   logic                   s, level_nxt, rise, fall, ev;
   logic                   flag_nxt;
   logic [CNT_W-1:0]       count_nxt;

   assign s = sync_q[SYNC_STAGES-1];

   // Level only moves after FILTER_LEN consecutive mismatching samples.
   always_comb begin
      fc_nxt    = fc;
      level_nxt = level;
      if (s == level) begin
         fc_nxt = '0;
      end else if (fc == FC_LAST) begin
         level_nxt = s;
         fc_nxt    = '0;
      end else begin
         fc_nxt = fc + FC_W'(1);
      end
   end

   assign rise = level_nxt & ~level;
   assign fall = ~level_nxt & level;
   assign ev   = (rise & mode[0]) | (fall & mode[1]);

   // An event on the same edge as clr wins: flag stays set, counter restarts at 1.
   always_comb begin
      flag_nxt  = flag;
      count_nxt = count;
      if (clr) begin
         flag_nxt  = 1'b0;
         count_nxt = '0;
      end
      if (ev) begin
         flag_nxt = 1'b1;
         if (clr)
            count_nxt = CNT_W'(1);
         else if (count != CNT_MAX)
            count_nxt = count + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         fc     <= '0;
         level  <= 1'b0;
         pe     <= 1'b0;
         flag   <= 1'b0;
         count  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
         fc     <= fc_nxt;
         level  <= level_nxt;
         pe     <= ev;
         flag   <= flag_nxt;
         count  <= count_nxt;
      end
   end
endmodule

// File: tb/tb_edge_detect_multi.sv
// Scoreboarded bench for edge_detect_multi: directed plan phases plus a random
// phase, all outputs compared each cycle against a window-based reference model.

module tb_edge_detect_multi;
   localparam int CH   = 4;
   localparam int SS   = 2;
   localparam int FL   = 3;
   localparam int CW   = 4;
   localparam int MW   = 2 * CH;
   localparam int CMAX = (1 << CW) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [CH-1:0]    sig, clr;
   logic [MW-1:0]    mode;
   logic [CH-1:0]    level, pe, flag;
   logic [CW*CH-1:0] count;

   edge_detect_multi #(
      .CHANNELS (CH), .SYNC_STAGES (SS), .FILTER_LEN (FL), .CNT_W (CW)
   ) dut (
      .clk (clk), .rst (rst), .sig (sig), .mode (mode), .clr (clr),
      .level (level), .pe (pe), .flag (flag), .count (count)
   );

   always #10 clk = ~clk;

   typedef struct packed {
      logic [CH-1:0]    lvl;
      logic [CH-1:0]    pe;
      logic [CH-1:0]    flag;
      logic [CW*CH-1:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick(input int c);
      repeat (c) @(negedge clk);
   endtask

   function automatic logic [CW-1:0] cnt_of(input int ch);
      return count[CW*ch +: CW];
   endfunction

   // Reference model: s at edge n is the input captured SS edges earlier; level
   // flips when the last FL samples all disagree with it and at least FL edges
   // have passed since the previous flip or reset.
   logic [CH-1:0] cap [0:8191];
   logic [CH-1:0] sat [0:8191];
   int            n = 0;
   int            last_chg [CH];
   int            m_cnt [CH];
   logic [CH-1:0] m_lvl = '0, m_pe = '0, m_flag = '0;

   initial begin
      exp_t          e;
      logic [CH-1:0] s_n;
      bit            chg, en;
      for (int i = 0; i < CH; i++) begin
         last_chg[i] = 0;
         m_cnt[i]    = 0;
      end
      forever begin
         @(posedge clk);
         s_n    = (n >= SS) ? cap[n-SS] : '0;
         sat[n] = s_n;
         if (rst) begin
            for (int k = 0; k < SS; k++) if (n - k >= 0) cap[n-k] = '0;
            m_lvl  = '0;
            m_pe   = '0;
            m_flag = '0;
            for (int i = 0; i < CH; i++) begin
               m_cnt[i]    = 0;
               last_chg[i] = n;
            end
         end else begin
            cap[n] = sig;
            for (int i = 0; i < CH; i++) begin
               chg = (n - last_chg[i] >= FL);
               if (chg)
                  for (int k = 0; k < FL; k++) if (sat[n-k][i] == m_lvl[i]) chg = 0;
               en = 0;
               if (chg) begin
                  en          = m_lvl[i] ? mode[2*i+1] : mode[2*i];
                  m_lvl[i]    = ~m_lvl[i];
                  last_chg[i] = n;
               end
               m_pe[i] = en;
               if (en) m_flag[i] = 1'b1;
               else if (clr[i]) m_flag[i] = 1'b0;
               if (clr[i]) m_cnt[i] = en ? 1 : 0;
               else if (en && m_cnt[i] < CMAX) m_cnt[i]++;
            end
         end
         e.lvl  = m_lvl;
         e.pe   = m_pe;
         e.flag = m_flag;
         for (int i = 0; i < CH; i++) e.cnt[CW*i +: CW] = CW'(m_cnt[i]);
         sb.push_back(e);
         n++;
      end
   end

   // Monitor: compare every presented output cycle and tally pulses/toggles.
   int            pe_cnt [CH];
   int            fall_cnt [CH];
   int            tog_cnt [CH];
   logic [CH-1:0] prev_lvl = '0;

   initial begin
      exp_t e;
      for (int i = 0; i < CH; i++) begin
         pe_cnt[i]   = 0;
         fall_cnt[i] = 0;
         tog_cnt[i]  = 0;
      end
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_level", 64'(level), 64'(e.lvl));
            chk("sb_pe",    64'(pe),    64'(e.pe));
            chk("sb_flag",  64'(flag),  64'(e.flag));
            chk("sb_count", 64'(count), 64'(e.cnt));
         end
         for (int i = 0; i < CH; i++) begin
            if (pe[i] === 1'b1) begin
               pe_cnt[i]++;
               if (level[i] === 1'b0) fall_cnt[i]++;
            end
            if (level[i] !== prev_lvl[i]) tog_cnt[i]++;
         end
         prev_lvl = level;
      end
   end

   initial begin
      int b_pe, b_fall, b_tog;
      rst  = 1'b1;
      sig  = '0;
      clr  = '0;
      mode = {CH{2'b01}};
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_zero", 64'({level, pe, flag, count}), 64'd0);
      rst = 1'b0;
      tick(2);

      // rising path on ch0, sig driven off-edge at 100 ns
      sig[0] = 1'b1;
      tick(4);
      chk("rise_before_edge5", 64'({level[0], pe[0]}), 64'd0);
      tick(1);
      chk("rise_edge5", 64'({level[0], pe[0]}), 64'b11);
      tick(1);
      chk("rise_pe_one_cycle", 64'(pe[0]), 64'd0);
      tick(6);
      chk("rise_flag", 64'(flag[0]), 64'd1);
      chk("rise_count", 64'(cnt_of(0)), 64'd1);
      chk("rise_others", 64'({level[3:1], flag[3:1], count[CW*CH-1:CW]}), 64'd0);

      // glitch rejection on ch1
      b_pe = pe_cnt[1]; b_tog = tog_cnt[1];
      sig[1] = 1'b1; tick(2); sig[1] = 1'b0; tick(10);
      chk("glitch2_pe", 64'(pe_cnt[1] - b_pe), 64'd0);
      chk("glitch2_state", 64'({level[1], flag[1], cnt_of(1)}), 64'd0);
      sig[1] = 1'b1; tick(3); sig[1] = 1'b0; tick(10);
      chk("pulse3_pe", 64'(pe_cnt[1] - b_pe), 64'd1);
      chk("pulse3_toggles", 64'(tog_cnt[1] - b_tog), 64'd2);
      chk("pulse3_count", 64'(cnt_of(1)), 64'd1);

      // modes on ch2: both, fall only, off
      mode[5:4] = 2'b11;
      b_pe = pe_cnt[2];
      repeat (4) begin sig[2] = 1'b1; tick(10); sig[2] = 1'b0; tick(10); end
      chk("mode11_pe", 64'(pe_cnt[2] - b_pe), 64'd8);
      chk("mode11_count", 64'(cnt_of(2)), 64'd8);
      mode[5:4] = 2'b10;
      b_pe = pe_cnt[2]; b_fall = fall_cnt[2];
      repeat (4) begin sig[2] = 1'b1; tick(10); sig[2] = 1'b0; tick(10); end
      chk("mode10_pe", 64'(pe_cnt[2] - b_pe), 64'd4);
      chk("mode10_on_fall", 64'(fall_cnt[2] - b_fall), 64'd4);
      chk("mode10_count", 64'(cnt_of(2)), 64'd12);
      mode[5:4] = 2'b00;
      b_pe = pe_cnt[2]; b_tog = tog_cnt[2];
      repeat (4) begin sig[2] = 1'b1; tick(10); sig[2] = 1'b0; tick(10); end
      chk("mode00_pe", 64'(pe_cnt[2] - b_pe), 64'd0);
      chk("mode00_toggles", 64'(tog_cnt[2] - b_tog), 64'd8);
      chk("mode00_count", 64'(cnt_of(2)), 64'd12);

      // saturation on ch3
      b_pe = pe_cnt[3];
      repeat (20) begin sig[3] = 1'b1; tick(5); sig[3] = 1'b0; tick(5); end
      chk("sat_pe", 64'(pe_cnt[3] - b_pe), 64'd20);
      chk("sat_count", 64'(cnt_of(3)), 64'd15);
      chk("sat_flag", 64'(flag[3]), 64'd1);
      clr[3] = 1'b1; tick(1); clr[3] = 1'b0;
      chk("sat_clr", 64'({flag[3], cnt_of(3)}), 64'd0);

      // clr coinciding with an event on ch0
      sig[0] = 1'b0; tick(10);
      clr[0] = 1'b1; tick(1); clr[0] = 1'b0;
      chk("simul_pre_clr", 64'({flag[0], cnt_of(0)}), 64'd0);
      sig[0] = 1'b1; tick(4);
      clr[0] = 1'b1; tick(1); clr[0] = 1'b0;
      chk("simul_pe", 64'(pe[0]), 64'd1);
      chk("simul_flag", 64'(flag[0]), 64'd1);
      chk("simul_count", 64'(cnt_of(0)), 64'd1);

      // reset mid-filter on ch0
      sig[0] = 1'b0; tick(10);
      sig[0] = 1'b1; tick(3);
      chk("midrst_level_low", 64'(level[0]), 64'd0);
      rst = 1'b1; tick(1);
      chk("midrst_all_zero", 64'({level, pe, flag, count}), 64'd0);
      rst = 1'b0;
      b_pe = pe_cnt[0];
      tick(4);
      chk("midrst_pe_early", 64'(pe[0]), 64'd0);
      tick(1);
      chk("midrst_pe_edge5", 64'(pe[0]), 64'd1);
      tick(10);
      chk("midrst_pe_once", 64'(pe_cnt[0] - b_pe), 64'd1);
      chk("midrst_count", 64'(cnt_of(0)), 64'd1);

      // random traffic, model-checked every cycle
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < CH; i++)
            if ($urandom_range(0, 1 + 2 * i) == 0) sig[i] = ~sig[i];
         if ($urandom_range(0, 49) == 0) mode = MW'($urandom);
         clr = ($urandom_range(0, 29) == 0) ? CH'($urandom) : '0;
         rst = ($urandom_range(0, 399) == 0);
         tick(1);
      end
      rst = 1'b0;
      clr = '0;
      tick(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
